imem_fetch_responder: RTL

- Instruction-memory responder: the memory end of the processor's fetch interface.
- Accepts fetch requests (byte address) over a valid/ready handshake and returns 32-bit instruction words in order after a fixed latency.
- Has a program-load write port so benches and boot logic can fill memory.
- Sits between the Processor fetch stage and a word-addressed storage array; in-flight responses are buffered so fetch back-pressure never drops data.

---
 rtl/imem_fetch_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: in-order instruction fetch responder with fixed latency, credit-limited output FIFO and a program-load port.
// Optional macro IMEM_BOUNDS_CHECK_EN enables misaligned/out-of-range detection on rsp_err.
module imem_fetch_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam logic [FW:0] FULL = (FW + 1)'(FIFO_DEPTH);
`ifdef IMEM_BOUNDS_CHECK_EN
   localparam int EW = 33;
`else
   localparam int EW = 32;
`endif
   logic [31:0]   mem [DEPTH_WORDS];
   logic [EW-1:0] fifo_q [FIFO_DEPTH];
   logic [AW-1:0] rd_idx, ld_idx;
   logic [31:0]   rd_word;
   logic [EW-1:0] ent, wr_ent, head;
   logic          acc, pop, wr_v, rdy_q, unused;
   logic [FW:0]   cnt_q, cnt_d, wp_q, rp_q;
   assign rd_idx  = req_addr[AW+1:2];
   assign ld_idx  = ld_addr[AW+1:2];
   assign rd_word = (ld_en && ld_idx == rd_idx) ? ld_data : mem[rd_idx];
`ifdef IMEM_BOUNDS_CHECK_EN
   logic err;
   assign err     = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
   assign ent     = {err, err ? 32'h0 : rd_word};
   assign rsp_err = rsp_valid & head[32];
   assign unused  = ^{ld_addr[31:AW+2], ld_addr[1:0]};
`else
   assign ent     = rd_word;
   assign rsp_err = 1'b0;
   assign unused  = ^{ld_addr[31:AW+2], ld_addr[1:0], req_addr[31:AW+2], req_addr[1:0]};
`endif
   assign req_ready = rdy_q && (cnt_q < FULL);
   assign acc       = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;
   assign cnt_d     = cnt_q + (FW + 1)'(acc) - (FW + 1)'(pop);
   assign rsp_valid = wp_q != rp_q;
   assign head      = fifo_q[rp_q[FW-1:0]];
   assign rsp_data  = rsp_valid ? head[31:0] : 32'h0;
   // The FIFO write is the last of the LATENCY register stages, so only LATENCY-1 pipeline registers precede it.
   if (LATENCY == 1) begin : g_direct
      assign wr_v   = acc;
      assign wr_ent = ent;
   end else begin : g_pipe
      logic [LATENCY-2:0] pv_q;
      logic [EW-1:0]      pd_q [LATENCY-1];
      // Valid bits of the latency pipeline; cleared by reset so in-flight requests vanish.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) pv_q <= '0;
         else begin
            pv_q[0] <= acc;
            for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
         end
      end
      // Payload of the latency pipeline; qualified by the valid bits so no reset is needed.
      always_ff @(posedge clk) begin
         pd_q[0] <= ent;
         for (int i = 1; i < LATENCY - 1; i++) pd_q[i] <= pd_q[i-1];
      end
      assign wr_v   = pv_q[LATENCY-2];
      assign wr_ent = pd_q[LATENCY-2];
   end
   // Credit counter, FIFO pointers and the post-reset ready enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q <= 1'b0;
         cnt_q <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
      end else begin
         rdy_q <= 1'b1;
         cnt_q <= cnt_d;
         wp_q  <= wp_q + (FW + 1)'(wr_v);
         rp_q  <= rp_q + (FW + 1)'(pop);
      end
   end
   // FIFO storage; the write never overflows because credits bound the outstanding requests.
   always_ff @(posedge clk) begin
      if (wr_v) fifo_q[wp_q[FW-1:0]] <= wr_ent;
   end
   // Program-load write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_data;
   end
endmodule
